// File: rtl/bin_to_bcd4_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter feeding the
// quad seven-segment display driver.
package bin_to_bcd4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS  = 4;
    localparam int BCD_FIELDS  = 5;
    localparam int BCD_W       = 4 * BCD_FIELDS;
    localparam int MAX_DISPLAY = 9999;

    localparam logic [3:0] SAT_DIGIT = 4'd9;

    // Double-dabble correction: a field of 5..9 would carry wrongly after a
    // doubling, so it is pre-biased by 3.
    function automatic logic [3:0] add3_if_ge5(input logic [3:0] d);
        return (d >= 4'd5) ? (d + 4'd3) : d;
    endfunction

endpackage

// File: rtl/bin_to_bcd4_digit_adjust.sv
// Combinational per-field +3 adjust used ahead of each shift step.
module bcd_digit_adjust
    import bin_to_bcd4_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    always_comb begin
        o_digit = add3_if_ge5(i_digit);
    end

endmodule

// File: rtl/bin_to_bcd4.sv
// Shift-add-3 binary-to-BCD converter, one bit per clock, with digits that
// update atomically on completion and saturate to 9999 on overflow.
module bin_to_bcd4
    import bin_to_bcd4_pkg::*;
#(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       num0,
    output logic [3:0]       num1,
    output logic [3:0]       num2,
    output logic [3:0]       num3
);

    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W);

    // Narrow inputs can never exceed the display range, so the flag folds away.
    localparam bit OVF_POSSIBLE = (((1 << BIN_W) - 1) > MAX_DISPLAY);

    state_t r_state;
    state_t w_state_nxt;

    logic [SR_W-1:0]                r_sr;
    logic [SR_W-1:0]                w_adj;
    logic [SR_W-1:0]                w_shift;
    logic [CNT_W-1:0]               r_count;
    logic [NUM_DIGITS-1:0][3:0]     r_num;
    logic                           r_ovf;
    logic                           w_accept;
    logic                           w_last;
    logic                           w_ovf_nxt;

    // Adjust every BCD field, then shift the whole {bcd, bin} word left by one.
    for (genvar f = 0; f < BCD_FIELDS; f++) begin : g_adj
        bcd_digit_adjust u_adj (
            .i_digit (r_sr[BIN_W + 4*f +: 4]),
            .o_digit (w_adj[BIN_W + 4*f +: 4])
        );
    end

    assign w_adj[BIN_W-1:0] = r_sr[BIN_W-1:0];
    assign w_shift          = w_adj << 1;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_last    = (r_state == ST_SHIFT) && (r_count == CNT_W'(BIN_W - 1));
    assign w_ovf_nxt = OVF_POSSIBLE && (w_shift[SR_W-1 -: 4] != 4'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_nxt = ST_SHIFT;
            ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE:              w_state_nxt = ST_IDLE;
            default:              w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            ST_SHIFT: busy = 1'b1;
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr    <= '0;
            r_count <= '0;
            r_num   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sr    <= {{BCD_W{1'b0}}, bin_in};
                r_count <= '0;
            end else if (r_state == ST_SHIFT) begin
                r_sr    <= w_shift;
                r_count <= r_count + 1'b1;
            end
            // Digits are loaded only here, from the final shifted value.
            if (w_last) begin
                r_ovf <= w_ovf_nxt;
                for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
                    r_num[d] <= w_ovf_nxt ? SAT_DIGIT : w_shift[BIN_W + 4*d +: 4];
                end
            end
        end
    end

    assign ovf  = r_ovf;
    assign num0 = r_num[0];
    assign num1 = r_num[1];
    assign num2 = r_num[2];
    assign num3 = r_num[3];

endmodule

// File: doc/bin_to_bcd4.md
Name: bin_to_bcd4

Overview:
- Sequential binary-to-BCD converter. Produces the four digit nibbles consumed by the quad seven-segment display driver.
- Takes an unsigned binary value plus a start pulse and runs a shift-add-3 (double-dabble) conversion, one bit per clock.
- Presents num0..num3 as registered, atomically updated digits. Saturates to 9999 with an overflow flag.

Parameters:
- BIN_W, 14, width of the binary input; legal range 4..16.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- bin_in  input  BIN_W  unsigned value to convert; sampled only when a start is accepted.
- start  input  1  conversion request; accepted only in IDLE.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; digit outputs are valid from this cycle.
- ovf  output  1  latched with digits; 1 when bin_in > 9999.
- num0  output  4  ones digit (rightmost).
- num1  output  4  tens digit.
- num2  output  4  hundreds digit.
- num3  output  4  thousands digit (leftmost).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, ovf=0, num0..num3=0. All internal shift and count registers are cleared.
- Reset mid-operation: the conversion is aborted immediately. Outputs return to the reset values; no done pulse is issued.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge k: load shift register {20'b0, bin_in}, count=0, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, on each edge:
  - Every 4-bit BCD field (5 fields, 20 bits internally) that is >=5 gets +3.
  - Then the combined {bcd, bin} register shifts left by 1; count++.
  - On the edge where count reaches BIN_W-1, the final adjusted and shifted value loads the output registers and the state goes to DONE.
  - Total BIN_W SHIFT edges (k+1 .. k+BIN_W).
- Output load at the DONE entry:
  - ovf = (fifth BCD field != 0).
  - If ovf=1: num3..num0 = 9,9,9,9. Otherwise they take the low four BCD fields.
  - Digits only ever change on this edge, so there is no partial update visible to the display.
- DONE: done=1 for exactly this one cycle; go to IDLE on the next edge.
- Latency: done is high in the cycle following edge k+BIN_W, where k is the edge that accepted start.
- Throughput: one conversion per BIN_W+2 cycles with start held high.
- busy: 1 in SHIFT and DONE; 0 in IDLE.
- start handling:
  - Ignored in SHIFT and DONE; no queueing.
  - Held high continuously: a new conversion is accepted on the first IDLE edge after DONE.
- bin_in changes after acceptance do not affect the result.
- Widths:
  - Internal BCD is 5×4 bits, which is sufficient for BIN_W<=16 (max 65535).
  - Each +3 adjust is 4-bit, performed per field before the shift.
- Counter width: clog2(BIN_W).

Decomposition:
- Shared package:
  - State encoding constants (IDLE, SHIFT, DONE).
  - NUM_DIGITS=4, BCD_FIELDS=5.
  - MAX_DISPLAY=9999.
  - Saturation digit value 4'd9.
- One natural sub-module: bcd_digit_adjust. It is combinational, takes 4 bits in and returns 4 bits out (+3 if >=5). It is instantiated per BCD field inside the SHIFT datapath.

Test Plan:
- Reset: assert reset asynchronously between edges -> immediately busy=0, done=0, ovf=0, num3..num0=0,0,0,0.
- BIN_W=14, bin_in=1234, start pulse at edge k -> busy from k; done high only in the cycle after edge k+14; num3..num0=1,2,3,4; ovf=0.
- Boundaries:
  - bin_in=0 -> 0,0,0,0, ovf=0.
  - bin_in=9999 -> 9,9,9,9, ovf=0.
  - bin_in=10000 -> 9,9,9,9, ovf=1.
  - bin_in=16383 -> 9,9,9,9, ovf=1.
- Start while busy: start with 42, then start with 777 at edge k+5 -> one done only; result 0,0,4,2. Changing bin_in during SHIFT has no effect.
- Reset mid-conversion: start 5678, assert reset at cycle k+6 -> outputs zero, no done. After release, start 305 -> 0,3,0,5 after BIN_W+1 cycles.
- Start held high with bin_in stepping 1,2,3 each accept -> done pulses exactly BIN_W+2 cycles apart; digits 0001, 0002, 0003. Digits stay stable between done pulses.
